// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared fetch-side definitions for the branch redirect controller:
// FSM encoding, PC step and target alignment.
package branch_redirect_ctrl_pkg;

    localparam int unsigned XLEN = 64;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;
    localparam int unsigned FLUSH_CNT_W = 4;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } state_e;

    // Instructions are word aligned; the low two target bits are dropped.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
        return {target[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Branch resolution inputs and fetch/pipeline control outputs of the redirect controller.
interface branch_redirect_ctrl_if
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) ();

    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            stall;
    logic [XLEN-1:0] pc_out;
    logic            pc_write;
    logic            if_id_write;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic            redirect_busy;
    logic            misalign_err;
    logic [CNT_W-1:0] redirect_count;

    // Master: EX-stage / hazard side driving requests and observing fetch control.
    modport master (
        output branch_taken,
        output branch_target,
        output stall,
        input  pc_out,
        input  pc_write,
        input  if_id_write,
        input  if_id_flush,
        input  id_ex_flush,
        input  redirect_busy,
        input  misalign_err,
        input  redirect_count
    );

    modport slave (
        input  branch_taken,
        input  branch_target,
        input  stall,
        output pc_out,
        output pc_write,
        output if_id_write,
        output if_id_flush,
        output id_ex_flush,
        output redirect_busy,
        output misalign_err,
        output redirect_count
    );

endinterface

// File: rtl/branch_redirect_ctrl.sv
// Owns the fetch PC: applies taken-branch redirects with a multi-cycle squash window,
// load-use stalls, and keeps a sticky misalignment flag plus a saturating redirect count.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int unsigned     FLUSH_CYCLES = 1,
    parameter int unsigned     CNT_W        = 32
) (
    input logic                   clk,
    input logic                   reset,
    branch_redirect_ctrl_if.slave bus
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam bit HAS_FLUSH = (FLUSH_CYCLES > 1);

    state_e                 state_q, state_d;
    logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic                   misalign_q, misalign_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic accept;
    logic pc_write_c;
    logic if_id_write_c;
    logic if_id_flush_c;
    logic id_ex_flush_c;
    logic busy_c;

    // Control decode: branch beats stall because the stalled instruction is wrong-path.
    always_comb begin
        accept        = 1'b0;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        busy_c        = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.branch_taken) begin
                    accept        = 1'b1;
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (bus.stall) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    id_ex_flush_c = 1'b1;
                end
            end
            StFlush: begin
                busy_c        = 1'b1;
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;

        if (accept) begin
            pc_d = align_target(bus.branch_target);
            if (bus.branch_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (HAS_FLUSH) begin
                state_d = StFlush;
                fcnt_d  = FLUSH_LOAD;
            end
        end else if (pc_write_c) begin
            pc_d = pc_q + PC_STEP;
        end

        if (state_q == StFlush) begin
            fcnt_d = fcnt_q - FLUSH_CNT_W'(1);
            if (fcnt_q == FLUSH_CNT_W'(1)) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StRun;
            fcnt_q     <= '0;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.pc_out         = pc_q;
    assign bus.pc_write       = pc_write_c;
    assign bus.if_id_write    = if_id_write_c;
    assign bus.if_id_flush    = if_id_flush_c;
    assign bus.id_ex_flush    = id_ex_flush_c;
    assign bus.redirect_busy  = busy_c;
    assign bus.misalign_err   = misalign_q;
    assign bus.redirect_count = cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench: expected PCs are queued as stimulus is applied and checked after each edge.
module tb_branch_redirect_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] exp_q[$];
    logic [63:0] want;

    always #5 clk = ~clk;

    branch_redirect_ctrl_if #(.CNT_W(32)) bus1 ();
    branch_redirect_ctrl_if #(.CNT_W(2))  bus3 ();

    branch_redirect_ctrl #(
        .RESET_PC    (64'h0),
        .FLUSH_CYCLES(1),
        .CNT_W       (32)
    ) dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    branch_redirect_ctrl #(
        .RESET_PC    (64'h1000),
        .FLUSH_CYCLES(3),
        .CNT_W       (2)
    ) dut3 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus3)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set1(input logic bt, input logic [63:0] tgt, input logic st);
        bus1.branch_taken  = bt;
        bus1.branch_target = tgt;
        bus1.stall         = st;
        #1;
    endtask

    task automatic set3(input logic bt, input logic [63:0] tgt, input logic st);
        bus3.branch_taken  = bt;
        bus3.branch_target = tgt;
        bus3.stall         = st;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set1(0, 64'h0, 0);
        set3(0, 64'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus1.pc_out !== 64'h0) begin
            errors++; $display("FAIL reset_pc1: got %h want %h", bus1.pc_out, 64'h0);
        end
        checks++;
        if (bus3.pc_out !== 64'h1000) begin
            errors++; $display("FAIL reset_pc3: got %h want %h", bus3.pc_out, 64'h1000);
        end
        checks++;
        if ({bus1.if_id_flush, bus1.id_ex_flush, bus1.misalign_err, bus3.redirect_busy} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus1.if_id_flush, bus1.id_ex_flush, bus1.misalign_err, bus3.redirect_busy});
        end
        checks++;
        if (bus1.redirect_count !== 32'd0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", bus1.redirect_count);
        end
    endtask

    task automatic test_idle;
        set1(0, 64'h0, 0);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(64'(i * 4));
            checks++;
            if ({bus1.if_id_flush, bus1.id_ex_flush, bus1.pc_write, bus1.if_id_write} !== 4'b0011) begin
                errors++;
                $display("FAIL idle_ctrl: got %b want 0011",
                         {bus1.if_id_flush, bus1.id_ex_flush, bus1.pc_write, bus1.if_id_write});
            end
            tick();
            want = exp_q.pop_front();
            checks++;
            if (bus1.pc_out !== want) begin
                errors++; $display("FAIL idle_pc: got %h want %h", bus1.pc_out, want);
            end
        end
        checks++;
        if (bus1.redirect_count !== 32'd0) begin
            errors++; $display("FAIL idle_count: got %0d want 0", bus1.redirect_count);
        end
    endtask

    task automatic test_branch;
        set1(1, 64'h100, 0);
        exp_q.push_back(64'h100);
        checks++;
        if ({bus1.if_id_flush, bus1.id_ex_flush, bus1.pc_write, bus1.if_id_write} !== 4'b1111) begin
            errors++;
            $display("FAIL branch_ctrl: got %b want 1111",
                     {bus1.if_id_flush, bus1.id_ex_flush, bus1.pc_write, bus1.if_id_write});
        end
        tick();
        want = exp_q.pop_front();
        checks++;
        if (bus1.pc_out !== want) begin
            errors++; $display("FAIL branch_pc: got %h want %h", bus1.pc_out, want);
        end
        set1(0, 64'h0, 0);
        checks++;
        if ({bus1.if_id_flush, bus1.id_ex_flush} !== 2'b00) begin
            errors++;
            $display("FAIL branch_flush_drop: got %b want 00", {bus1.if_id_flush, bus1.id_ex_flush});
        end
        exp_q.push_back(64'h104);
        tick();
        want = exp_q.pop_front();
        checks++;
        if (bus1.pc_out !== want) begin
            errors++; $display("FAIL branch_pc_next: got %h want %h", bus1.pc_out, want);
        end
        checks++;
        if (bus1.redirect_count !== 32'd1) begin
            errors++; $display("FAIL branch_count: got %0d want 1", bus1.redirect_count);
        end
    endtask

    task automatic test_stall;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        set1(0, 64'h0, 0);
        for (int i = 1; i <= 2; i++) begin
            exp_q.push_back(64'(i * 4));
            tick();
            want = exp_q.pop_front();
            checks++;
            if (bus1.pc_out !== want) begin
                errors++; $display("FAIL stall_pre_pc: got %h want %h", bus1.pc_out, want);
            end
        end
        set1(0, 64'h0, 1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({bus1.pc_write, bus1.if_id_write, bus1.id_ex_flush, bus1.if_id_flush} !== 4'b0010) begin
                errors++;
                $display("FAIL stall_ctrl: got %b want 0010",
                         {bus1.pc_write, bus1.if_id_write, bus1.id_ex_flush, bus1.if_id_flush});
            end
            exp_q.push_back(64'h8);
            tick();
            want = exp_q.pop_front();
            checks++;
            if (bus1.pc_out !== want) begin
                errors++; $display("FAIL stall_hold: got %h want %h", bus1.pc_out, want);
            end
        end
        set1(0, 64'h0, 0);
        exp_q.push_back(64'hC);
        tick();
        want = exp_q.pop_front();
        checks++;
        if (bus1.pc_out !== want) begin
            errors++; $display("FAIL stall_resume: got %h want %h", bus1.pc_out, want);
        end
    endtask

    task automatic test_stall_vs_branch;
        set1(1, 64'h200, 1);
        checks++;
        if ({bus1.pc_write, bus1.if_id_write, bus1.if_id_flush, bus1.id_ex_flush} !== 4'b1111) begin
            errors++;
            $display("FAIL prio_ctrl: got %b want 1111",
                     {bus1.pc_write, bus1.if_id_write, bus1.if_id_flush, bus1.id_ex_flush});
        end
        exp_q.push_back(64'h200);
        tick();
        want = exp_q.pop_front();
        checks++;
        if (bus1.pc_out !== want) begin
            errors++; $display("FAIL prio_pc: got %h want %h", bus1.pc_out, want);
        end
        checks++;
        if (bus1.redirect_count !== 32'd1) begin
            errors++; $display("FAIL prio_count: got %0d want 1", bus1.redirect_count);
        end
    endtask

    task automatic test_misalign;
        set1(1, 64'h102, 0);
        checks++;
        if (bus1.misalign_err !== 1'b0) begin
            errors++; $display("FAIL misalign_early: got %b want 0", bus1.misalign_err);
        end
        exp_q.push_back(64'h100);
        tick();
        want = exp_q.pop_front();
        checks++;
        if (bus1.pc_out !== want || bus1.misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL misalign_set: got pc=%h err=%b want pc=%h err=1",
                     bus1.pc_out, bus1.misalign_err, want);
        end
        set1(1, 64'h300, 0);
        exp_q.push_back(64'h300);
        tick();
        set1(0, 64'h0, 0);
        exp_q.push_back(64'h304);
        want = exp_q.pop_front();
        checks++;
        if (bus1.pc_out !== want) begin
            errors++; $display("FAIL misalign_pc2: got %h want %h", bus1.pc_out, want);
        end
        tick();
        want = exp_q.pop_front();
        checks++;
        if (bus1.pc_out !== want || bus1.misalign_err !== 1'b1 || bus1.redirect_count !== 32'd3) begin
            errors++;
            $display("FAIL misalign_sticky: got pc=%h err=%b cnt=%0d want pc=%h err=1 cnt=3",
                     bus1.pc_out, bus1.misalign_err, bus1.redirect_count, want);
        end
    endtask

    task automatic test_wrap;
        set1(1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        want = exp_q.pop_front();
        checks++;
        if (bus1.pc_out !== want) begin
            errors++; $display("FAIL wrap_top: got %h want %h", bus1.pc_out, want);
        end
        set1(0, 64'h0, 0);
        exp_q.push_back(64'h0);
        tick();
        want = exp_q.pop_front();
        checks++;
        if (bus1.pc_out !== want) begin
            errors++; $display("FAIL wrap_zero: got %h want %h", bus1.pc_out, want);
        end
    endtask

    task automatic test_flush3;
        set3(1, 64'h40, 0);
        checks++;
        if ({bus3.if_id_flush, bus3.id_ex_flush, bus3.redirect_busy} !== 3'b110) begin
            errors++;
            $display("FAIL f3_c0: got %b want 110",
                     {bus3.if_id_flush, bus3.id_ex_flush, bus3.redirect_busy});
        end
        exp_q.push_back(64'h40);
        tick();
        // Stall during the squash window must not hold the PC.
        set3(0, 64'h0, 1);
        want = exp_q.pop_front();
        checks++;
        if (bus3.pc_out !== want) begin
            errors++; $display("FAIL f3_pc1: got %h want %h", bus3.pc_out, want);
        end
        checks++;
        if ({bus3.if_id_flush, bus3.id_ex_flush, bus3.redirect_busy, bus3.pc_write, bus3.if_id_write}
            !== 5'b11111) begin
            errors++;
            $display("FAIL f3_c1: got %b want 11111", {bus3.if_id_flush, bus3.id_ex_flush,
                     bus3.redirect_busy, bus3.pc_write, bus3.if_id_write});
        end
        exp_q.push_back(64'h44);
        tick();
        set3(1, 64'h800, 0);
        want = exp_q.pop_front();
        checks++;
        if (bus3.pc_out !== want || bus3.redirect_busy !== 1'b1 || bus3.if_id_flush !== 1'b1) begin
            errors++;
            $display("FAIL f3_c2: got pc=%h busy=%b flush=%b want pc=%h busy=1 flush=1",
                     bus3.pc_out, bus3.redirect_busy, bus3.if_id_flush, want);
        end
        exp_q.push_back(64'h48);
        tick();
        set3(0, 64'h0, 0);
        want = exp_q.pop_front();
        checks++;
        if (bus3.pc_out !== want) begin
            errors++; $display("FAIL f3_pc3: got %h want %h", bus3.pc_out, want);
        end
        checks++;
        if ({bus3.if_id_flush, bus3.id_ex_flush, bus3.redirect_busy} !== 3'b000 ||
            bus3.redirect_count !== 2'd1) begin
            errors++;
            $display("FAIL f3_done: got flags=%b cnt=%0d want flags=000 cnt=1",
                     {bus3.if_id_flush, bus3.id_ex_flush, bus3.redirect_busy}, bus3.redirect_count);
        end
    endtask

    task automatic test_saturate;
        int exp_cnt = 1;
        for (int k = 0; k < 3; k++) begin
            logic [63:0] tgt = 64'h2000 + 64'(k * 'h100);
            set3(1, tgt, 0);
            exp_q.push_back(tgt);
            tick();
            set3(0, 64'h0, 0);
            exp_q.push_back(tgt + 64'd4);
            exp_q.push_back(tgt + 64'd8);
            for (int c = 0; c < 3; c++) begin
                want = exp_q.pop_front();
                checks++;
                if (bus3.pc_out !== want) begin
                    errors++; $display("FAIL sat_pc: got %h want %h", bus3.pc_out, want);
                end
                if (c < 2) tick();
            end
            exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
            checks++;
            if (bus3.redirect_count !== 2'(exp_cnt)) begin
                errors++; $display("FAIL sat_count: got %0d want %0d", bus3.redirect_count, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_flush;
        set3(1, 64'h506, 0);
        tick();
        set3(0, 64'h0, 0);
        checks++;
        if (bus3.redirect_busy !== 1'b1) begin
            errors++; $display("FAIL mid_busy: got %b want 1", bus3.redirect_busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus3.pc_out !== 64'h1000 || bus1.pc_out !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_pc: got %h/%h want 1000/0", bus3.pc_out, bus1.pc_out);
        end
        checks++;
        if ({bus3.redirect_busy, bus3.if_id_flush, bus3.id_ex_flush, bus3.misalign_err} !== 4'b0 ||
            bus3.redirect_count !== 2'd0 || bus1.redirect_count !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got flags=%b cnt3=%0d cnt1=%0d want 0000/0/0",
                     {bus3.redirect_busy, bus3.if_id_flush, bus3.id_ex_flush, bus3.misalign_err},
                     bus3.redirect_count, bus1.redirect_count);
        end
        reset = 1'b0;
        #1;
        exp_q.push_back(64'h1004);
        tick();
        want = exp_q.pop_front();
        checks++;
        if (bus3.pc_out !== want || bus3.redirect_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_resume: got pc=%h busy=%b want pc=%h busy=0",
                     bus3.pc_out, bus3.redirect_busy, want);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_branch();
        test_stall();
        test_stall_vs_branch();
        test_misalign();
        test_wrap();
        test_flush3();
        test_saturate();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
